// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game flow controller and the HUD block:
//   - flow state encodings (TITLE/PLAY/OVER/CLEAR)
//   - centre banner geometry (16x32 characters, 11 characters wide)
//   - banner strings and colours
// No ports; imported with "import game_pkg::*;".
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2,
    CLEAR = 2'd3
  } flow_state_t;

  // Banner geometry: 8x16 font glyphs drawn at 2x scale.
  localparam int CHAR_W  = 16;
  localparam int CHAR_H  = 32;
  localparam int BAN_LEN = 11;
  localparam int BAN_W   = CHAR_W * BAN_LEN;

  // Banner text, space padded to BAN_LEN characters, leftmost char in the MSBs.
  localparam logic [87:0] STR_TITLE = "PRESS START";
  localparam logic [87:0] STR_OVER  = "GAME OVER  ";
  localparam logic [87:0] STR_CLEAR = "  CLEAR!   ";
  localparam logic [87:0] STR_BLANK = "           ";

  // Banner colours (4 bits per channel, RGB).
  localparam logic [11:0] RGB_TITLE = 12'hfff;
  localparam logic [11:0] RGB_OVER  = 12'hf00;
  localparam logic [11:0] RGB_CLEAR = 12'h0f0;

endpackage

// File: rtl/btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
// Two-flop synchroniser for a raw button followed by a registered rising-edge
// detector. A press yields exactly one pulse cycle, three clocks after the
// button rises. A button that is already held when reset is released is not
// reported: the detector stays disarmed until the synchronised button has
// been seen low after reset, so a release and a fresh press are required.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   btn    in   raw asynchronous button, active-high
//   pulse  out  one-cycle pulse per press
// -----------------------------------------------------------------------------
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic fill1_r;
  logic fill2_r;
  logic armed_r;
  logic pulse_r;

  // Synchroniser chain, edge reference, arming and registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill1_r <= 1'b0;
      fill2_r <= 1'b0;
      armed_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      // fill2_r marks that sync2_r now holds a real post-reset sample rather
      // than its reset value, so arming only trusts a genuine "released".
      fill1_r <= 1'b1;
      fill2_r <= fill1_r;
      if (fill2_r && !sync2_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      pulse_r <= sync2_r & ~prev_r & armed_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/font_rom_vhd.sv
// -----------------------------------------------------------------------------
// font_rom_vhd
// Shared 8x16 font ROM with a registered (1 clock) read. Address is
// {char_code[6:0], row[3:0]}; data bit 7 is the leftmost pixel. Glyphs are a
// 5x7 face placed in rows 4..10, pixel columns 1..5; unlisted codes (including
// space) read as blank.
// Ports:
//   clk   in   clock
//   addr  in   {char_code, row}
//   data  out  pixel row, registered
// -----------------------------------------------------------------------------
module font_rom_vhd (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [34:0] glyph_s;
  logic [4:0]  face_row_s;
  logic [7:0]  data_r;

  // Glyph lookup: seven 5-bit rows, top row in the MSBs.
  always_comb begin
    case (addr[10:4])
      7'h21:   glyph_s = 35'b00100_00100_00100_00100_00100_00000_00100; // !
      7'h41:   glyph_s = 35'b01110_10001_10001_11111_10001_10001_10001; // A
      7'h43:   glyph_s = 35'b01110_10001_10000_10000_10000_10001_01110; // C
      7'h45:   glyph_s = 35'b11111_10000_10000_11110_10000_10000_11111; // E
      7'h47:   glyph_s = 35'b01110_10001_10000_10111_10001_10001_01111; // G
      7'h4c:   glyph_s = 35'b10000_10000_10000_10000_10000_10000_11111; // L
      7'h4d:   glyph_s = 35'b10001_11011_10101_10101_10001_10001_10001; // M
      7'h4f:   glyph_s = 35'b01110_10001_10001_10001_10001_10001_01110; // O
      7'h50:   glyph_s = 35'b11110_10001_10001_11110_10000_10000_10000; // P
      7'h52:   glyph_s = 35'b11110_10001_10001_11110_10100_10010_10001; // R
      7'h53:   glyph_s = 35'b01111_10000_10000_01110_00001_00001_11110; // S
      7'h54:   glyph_s = 35'b11111_00100_00100_00100_00100_00100_00100; // T
      7'h56:   glyph_s = 35'b10001_10001_10001_10001_10001_01010_00100; // V
      default: glyph_s = 35'd0;
    endcase
  end

  // Row select within the 16-row cell.
  always_comb begin
    case (addr[3:0])
      4'd4:    face_row_s = glyph_s[34:30];
      4'd5:    face_row_s = glyph_s[29:25];
      4'd6:    face_row_s = glyph_s[24:20];
      4'd7:    face_row_s = glyph_s[19:15];
      4'd8:    face_row_s = glyph_s[14:10];
      4'd9:    face_row_s = glyph_s[9:5];
      4'd10:   face_row_s = glyph_s[4:0];
      default: face_row_s = 5'd0;
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    data_r <= {1'b0, face_row_s, 2'b00};
  end

  assign data = data_r;

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Game flow state machine (TITLE -> PLAY -> OVER/CLEAR -> TITLE) and the
// centre-screen banner renderer. The banner output lags x/y by one clock
// because of the font ROM read; the parent delays its own layers to match.
// Ports:
//   clk        in   pixel clock
//   rst        in   synchronous active-high reset
//   x, y       in   current pixel column / row (10 bits)
//   btn_start  in   raw start button, active-high
//   game_over  in   one-cycle pulse, lives exhausted
//   ending     in   one-cycle pulse, coin goal reached
//   game_st    out  1 while in PLAY
//   state      out  current flow state
//   restart    out  one-cycle pulse with the first PLAY cycle
//   on         out  banner pixel active (for x/y of the previous clock)
//   rgb        out  banner colour
// -----------------------------------------------------------------------------
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int BAN_X        = 232,
  parameter int BAN_Y        = 224
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_start,
  input  logic        game_over,
  input  logic        ending,
  output logic        game_st,
  output logic [1:0]  state,
  output logic        restart,
  output logic        on,
  output logic [11:0] rgb
);

  localparam int HOLD_W  = (HOLD_CYCLES  > 2) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [9:0] X_LO = 10'(BAN_X);
  localparam logic [9:0] X_HI = 10'(BAN_X + BAN_W);
  localparam logic [9:0] Y_LO = 10'(BAN_Y);
  localparam logic [9:0] Y_HI = 10'(BAN_Y + CHAR_H);

  logic               start_p_s;
  flow_state_t        state_r;
  flow_state_t        next_state_s;
  logic               restart_r;
  logic               game_st_r;
  logic               restart_set_s;
  logic               enter_hold_s;
  logic               enter_title_s;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_r;

  logic [6:0]  half_x_s;
  logic [3:0]  col_s;
  logic [2:0]  bit_s;
  logic [3:0]  row_s;
  logic        in_region_s;
  logic        banner_en_s;
  logic [87:0] str_s;
  logic [6:0]  char_s;
  logic [11:0] colour_s;
  logic [10:0] rom_addr_s;
  logic [7:0]  rom_data_s;
  logic        region_r;
  logic [2:0]  bit_r;
  logic        en_r;
  logic [11:0] rgb_r;

  btn_edge_sync u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .pulse (start_p_s)
  );

  // Flow state register plus the registered restart / play flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= TITLE;
      restart_r <= 1'b0;
      game_st_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      restart_r <= restart_set_s;
      game_st_r <= (next_state_s == PLAY);
    end
  end

  // Next-state logic; game_over beats ending when both arrive together.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      TITLE: begin
        if (start_p_s) next_state_s = PLAY;
        else           next_state_s = TITLE;
      end
      PLAY: begin
        if (game_over)   next_state_s = OVER;
        else if (ending) next_state_s = CLEAR;
        else             next_state_s = PLAY;
      end
      OVER, CLEAR: begin
        // A press during the lockout is dropped, not remembered.
        if (start_p_s && (hold_cnt_r == '0)) next_state_s = TITLE;
        else                                 next_state_s = state_r;
      end
      default: next_state_s = TITLE;
    endcase
  end

  // Transition decodes feeding the registered outputs and counters.
  always_comb begin
    restart_set_s = 1'b0;
    enter_hold_s  = 1'b0;
    enter_title_s = 1'b0;
    if ((state_r == TITLE) && (next_state_s == PLAY)) restart_set_s = 1'b1;
    else                                              restart_set_s = 1'b0;
    if (((next_state_s == OVER) || (next_state_s == CLEAR)) && (next_state_s != state_r))
      enter_hold_s = 1'b1;
    else
      enter_hold_s = 1'b0;
    if ((next_state_s == TITLE) && (state_r != TITLE)) enter_title_s = 1'b1;
    else                                               enter_title_s = 1'b0;
  end

  // Start-button lockout after reaching OVER or CLEAR; saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r <= '0;
    end else if (enter_hold_s) begin
      hold_cnt_r <= HOLD_LOAD;
    end else if (hold_cnt_r != '0) begin
      hold_cnt_r <= hold_cnt_r - 1'b1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Free-running blink timer; the phase flag restarts visible on TITLE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else begin
      if (blink_cnt_r == BLINK_LAST) blink_cnt_r <= '0;
      else                           blink_cnt_r <= blink_cnt_r + 1'b1;
      if (enter_title_s)                   blink_r <= 1'b0;
      else if (blink_cnt_r == BLINK_LAST)  blink_r <= ~blink_r;
      else                                 blink_r <= blink_r;
    end
  end

  // Banner coordinates: every font pixel covers a 2x2 screen block.
  assign half_x_s    = 7'((x - X_LO) >> 1);
  assign col_s       = half_x_s[6:3];
  assign bit_s       = half_x_s[2:0];
  assign row_s       = 4'((y - Y_LO) >> 1);
  assign in_region_s = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign banner_en_s = (state_r != PLAY) && !((state_r == TITLE) && blink_r);

  // Banner text and colour for the current state.
  always_comb begin
    str_s    = STR_BLANK;
    colour_s = RGB_TITLE;
    case (state_r)
      TITLE: begin
        str_s    = STR_TITLE;
        colour_s = RGB_TITLE;
      end
      OVER: begin
        str_s    = STR_OVER;
        colour_s = RGB_OVER;
      end
      CLEAR: begin
        str_s    = STR_CLEAR;
        colour_s = RGB_CLEAR;
      end
      default: begin
        str_s    = STR_BLANK;
        colour_s = RGB_TITLE;
      end
    endcase
  end

  // Character code for the current banner column (ASCII fits in 7 bits).
  always_comb begin
    case (col_s)
      4'd0:    char_s = str_s[86:80];
      4'd1:    char_s = str_s[78:72];
      4'd2:    char_s = str_s[70:64];
      4'd3:    char_s = str_s[62:56];
      4'd4:    char_s = str_s[54:48];
      4'd5:    char_s = str_s[46:40];
      4'd6:    char_s = str_s[38:32];
      4'd7:    char_s = str_s[30:24];
      4'd8:    char_s = str_s[22:16];
      4'd9:    char_s = str_s[14:8];
      4'd10:   char_s = str_s[6:0];
      default: char_s = 7'h20;
    endcase
  end

  assign rom_addr_s = {char_s, row_s};

  font_rom_vhd u_font (
    .clk  (clk),
    .addr (rom_addr_s),
    .data (rom_data_s)
  );

  // Align region, bit index, enable and colour with the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      region_r <= 1'b0;
      bit_r    <= 3'd0;
      en_r     <= 1'b0;
      rgb_r    <= RGB_TITLE;
    end else begin
      region_r <= in_region_s;
      bit_r    <= bit_s;
      en_r     <= banner_en_s;
      rgb_r    <= colour_s;
    end
  end

  // Font data bit 7 is the leftmost pixel of the glyph row.
  assign on      = region_r & rom_data_s[3'd7 - bit_r] & en_r;
  assign rgb     = rgb_r;
  assign state   = state_r;
  assign game_st = game_st_r;
  assign restart = restart_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus queues expected values tagged
// with the cycle they must appear on; a negedge monitor checks them.
module tb_game_flow_ctrl;

  localparam int HOLD  = 100;
  localparam int BLINK = 8;
  localparam int BX    = 232;
  localparam int BY    = 224;

  localparam int K_STATE = 0;
  localparam int K_GST   = 1;
  localparam int K_RST   = 2;
  localparam int K_ON    = 3;
  localparam int K_RGB   = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        btn;
  logic        go;
  logic        fin;
  logic        game_st;
  logic [1:0]  state;
  logic        restart;
  logic        on;
  logic [11:0] rgb;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic stim_done = 1'b0;

  game_flow_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .BLINK_CYCLES (BLINK),
    .BAN_X        (BX),
    .BAN_Y        (BY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .btn_start (btn),
    .game_over (go),
    .ending    (fin),
    .game_st   (game_st),
    .state     (state),
    .restart   (restart),
    .on        (on),
    .rgb       (rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_STATE: return "state";
      K_GST:   return "game_st";
      K_RST:   return "restart";
      K_ON:    return "on";
      K_RGB:   return "rgb";
      default: return "unknown";
    endcase
  endfunction

  // Row 4 of the 8x16 glyphs for "  CLEAR!   " (first row of each letter face).
  function automatic logic [7:0] clear_row4(input int col);
    case (col)
      2:       return 8'h38; // C
      3:       return 8'h40; // L
      4:       return 8'h7c; // E
      5:       return 8'h38; // A
      6:       return 8'h78; // R
      7:       return 8'h10; // !
      default: return 8'h00;
    endcase
  endfunction

  // Blink phase at cycle c, given TITLE entry at t and last reset cycle rl.
  function automatic logic blink_at(input int c, input int t, input int rl);
    int n;
    n = (c - rl) / BLINK - (t - rl) / BLINK;
    return n[0];
  endfunction

  task automatic exp_at(input int c, input int k, input logic [11:0] v);
    q.push_back('{c, k, v});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        case (q[i].kind)
          K_STATE: act = {10'd0, state};
          K_GST:   act = {11'd0, game_st};
          K_RST:   act = {11'd0, restart};
          K_ON:    act = {11'd0, on};
          K_RGB:   act = rgb;
          default: act = 12'd0;
        endcase
        checks = checks + 1;
        if (q[i].cyc < cyc) begin
          errors = errors + 1;
          $display("FAIL %s missed at cycle %0d (now %0d)", kname(q[i].kind), q[i].cyc, cyc);
        end else if (act !== q[i].val) begin
          errors = errors + 1;
          $display("FAIL %s at cycle %0d: got %h, want %h", kname(q[i].kind), cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
    if (stim_done && (q.size() == 0)) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (cyc > 5000) begin
      errors = errors + 1;
      checks = checks + 1;
      $display("FAIL timeout at cycle %0d with %0d expectations pending", cyc, q.size());
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    int r_last, p, g, e, t, k, ce;
    logic [7:0] gb;
    rst = 1'b1; btn = 1'b0; go = 1'b0; fin = 1'b0; x = 10'd0; y = 10'd0;

    // Reset values while reset is held.
    @(negedge clk);
    exp_at(cyc + 1, K_STATE, 12'd0);
    exp_at(cyc + 1, K_GST,   12'd0);
    exp_at(cyc + 1, K_RST,   12'd0);
    exp_at(cyc + 1, K_ON,    12'd0);
    exp_at(cyc + 1, K_RGB,   12'hfff);
    tick(2);
    rst = 1'b0;
    r_last = cyc;
    exp_at(cyc + 1, K_STATE, 12'd0);
    tick(5);

    // TITLE -> PLAY: start_p 3 clk after the press, state moves the clk after.
    p = cyc; btn = 1'b1;
    exp_at(p + 3, K_STATE, 12'd0);
    exp_at(p + 3, K_RST,   12'd0);
    exp_at(p + 3, K_GST,   12'd0);
    exp_at(p + 4, K_STATE, 12'd1);
    exp_at(p + 4, K_RST,   12'd1);
    exp_at(p + 4, K_GST,   12'd1);
    exp_at(p + 5, K_RST,   12'd0);
    exp_at(p + 5, K_STATE, 12'd1);
    tick(10); btn = 1'b0; tick(6);

    // Start press during PLAY is ignored.
    p = cyc; btn = 1'b1;
    exp_at(p + 4, K_STATE, 12'd1);
    exp_at(p + 8, K_STATE, 12'd1);
    tick(6); btn = 1'b0; tick(6);

    // game_over and ending together: OVER wins; a later ending is ignored.
    g = cyc; go = 1'b1; fin = 1'b1;
    exp_at(g + 1, K_STATE, 12'd2);
    exp_at(g + 1, K_GST,   12'd0);
    tick(1); go = 1'b0; fin = 1'b0; tick(2);
    fin = 1'b1;
    exp_at(cyc + 2, K_STATE, 12'd2);
    tick(1); fin = 1'b0;
    e = g + 1;

    // Lockout: press at +50 discarded, press at +120 returns to TITLE.
    wait_until(e + 50); btn = 1'b1;
    exp_at(e + 54, K_STATE, 12'd2);
    exp_at(e + 58, K_STATE, 12'd2);
    tick(5); btn = 1'b0;
    wait_until(e + 120);
    x = 10'(BX + 2); y = 10'(BY + 8);
    btn = 1'b1;
    exp_at(e + 123, K_STATE, 12'd2);
    exp_at(e + 124, K_STATE, 12'd0);
    exp_at(e + 124, K_RST,   12'd0);
    t = e + 124;

    // TITLE blink: a lit pixel of 'P' is gated off in alternate windows.
    for (int c = t + 1; c <= t + 24; c++) begin
      exp_at(c, K_ON, {11'd0, ~blink_at(c - 1, t, r_last)});
    end
    exp_at(t + 2, K_RGB, 12'hfff);
    tick(5); btn = 1'b0;

    // Back to PLAY, then ending -> CLEAR; game_over in CLEAR is ignored.
    wait_until(t + 30); p = cyc; btn = 1'b1;
    exp_at(p + 4, K_STATE, 12'd1);
    exp_at(p + 4, K_RST,   12'd1);
    tick(5); btn = 1'b0; tick(5);
    k = cyc; fin = 1'b1;
    exp_at(k + 1, K_STATE, 12'd3);
    exp_at(k + 1, K_GST,   12'd0);
    tick(1); fin = 1'b0; tick(1);
    go = 1'b1;
    exp_at(cyc + 2, K_STATE, 12'd3);
    tick(1); go = 1'b0; tick(2);
    ce = k + 1;

    // CLEAR banner sweep across one glyph row, one-clock lag.
    y = 10'(BY + 8);
    for (int i = 0; i < 176; i++) begin
      x = 10'(BX + i);
      gb = clear_row4(i / 16);
      exp_at(cyc + 1, K_ON, {11'd0, gb[7 - ((i / 2) % 8)]});
      if ((i % 40) == 0) exp_at(cyc + 1, K_RGB, 12'h0f0);
      tick(1);
    end
    x = 10'(BX + 176);
    exp_at(cyc + 1, K_ON, 12'd0);
    tick(1);
    x = 10'(BX + 36);
    exp_at(cyc + 1, K_ON, 12'd1);
    tick(1);
    y = 10'(BY + 32);
    exp_at(cyc + 1, K_ON, 12'd0);
    tick(1);

    // CLEAR -> TITLE -> PLAY, then reset mid-PLAY with the button held.
    wait_until(ce + 110); p = cyc; btn = 1'b1;
    exp_at(p + 4, K_STATE, 12'd0);
    tick(5); btn = 1'b0; tick(10);
    p = cyc; btn = 1'b1;
    exp_at(p + 4, K_STATE, 12'd1);
    exp_at(p + 4, K_RST,   12'd1);
    tick(10);
    rst = 1'b1;
    exp_at(cyc + 1, K_STATE, 12'd0);
    exp_at(cyc + 1, K_RST,   12'd0);
    exp_at(cyc + 1, K_GST,   12'd0);
    tick(1); rst = 1'b0;
    for (int d = 1; d <= 20; d++) begin
      exp_at(cyc + d, K_STATE, 12'd0);
      exp_at(cyc + d, K_RST,   12'd0);
    end
    tick(20); btn = 1'b0; tick(10);
    p = cyc; btn = 1'b1;
    exp_at(p + 3, K_STATE, 12'd0);
    exp_at(p + 4, K_STATE, 12'd1);
    exp_at(p + 4, K_RST,   12'd1);
    exp_at(p + 5, K_RST,   12'd0);
    tick(6); btn = 1'b0; tick(4);
    stim_done = 1'b1;
  end

endmodule
